adsr_poly: RTL and testbench

- N-voice, gate-driven ADSR envelope generator. Successor to the fixed-timing single-voice envelope block.
- Step sizes and sustain level are run-time inputs instead of compile-time constants.
- Sustain holds for as long as the voice's gate is high. Release starts on gate fall from any active phase.
- Sits between the per-voice note/gate logic and the oscillator amplitude multipliers. One envelope word per voice.

---
 rtl/adsr_poly.sv | 203 ++++++++++++++++++++
 tb/tb_adsr_poly.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_poly.sv
// adsr_poly: N-voice gate-driven ADSR envelope generator with run-time step sizes and sustain level.
// Optional build macro ADSR_EXP_RELEASE_EN selects an exponential release with a linear floor.

module adsr_voice #(
    parameter int unsigned      ACC_W     = 32,
    parameter int unsigned      OUT_W     = 16,
    parameter logic [ACC_W-1:0] A_MAX     = 32'h8000_0000,
    parameter int unsigned      EXP_SHIFT = 6
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             gate_in,
    input  logic             retrig_in,
    input  logic [ACC_W-1:0] attack_step_in,
    input  logic [ACC_W-1:0] decay_step_in,
    input  logic [ACC_W-1:0] sustain_in,
    input  logic [ACC_W-1:0] release_step_in,
    output logic [OUT_W-1:0] level_out,
    output logic             idle_out,
    output logic             idle_next_out,
    output logic             done_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    if (OUT_W > ACC_W || EXP_SHIFT >= ACC_W || A_MAX == '0) begin : g_bad_cfg
        $error("adsr_voice: inconsistent OUT_W / EXP_SHIFT / A_MAX");
    end

    state_t           state_q, state_d;
    logic [ACC_W-1:0] level_q, level_d;
    logic             gate_q;
    logic             idle_q;
    logic             done_q, done_d;

    logic             trig;
    logic             fall;
    logic [ACC_W:0]   attack_sum;
    logic [ACC_W:0]   decay_floor;
    logic [ACC_W-1:0] rel_dec;
    logic             rel_instant;

    assign trig = gate_in & (~gate_q | retrig_in);
    assign fall = ~gate_in & gate_q;

    // One extra bit so the peak and sustain-floor comparisons cannot wrap.
    assign attack_sum  = {1'b0, level_q} + {1'b0, attack_step_in};
    assign decay_floor = {1'b0, sustain_in} + {1'b0, decay_step_in};

`ifdef ADSR_EXP_RELEASE_EN
    logic [ACC_W-1:0] rel_exp;
    logic [ACC_W-1:0] rel_floor;

    // A zero release step still needs a 1 LSB floor or the tail never reaches zero.
    assign rel_exp     = level_q >> EXP_SHIFT;
    assign rel_floor   = (release_step_in == '0) ? {{(ACC_W-1){1'b0}}, 1'b1} : release_step_in;
    assign rel_dec     = (rel_exp > rel_floor) ? rel_exp : rel_floor;
    assign rel_instant = 1'b0;
`else
    assign rel_dec     = release_step_in;
    assign rel_instant = (release_step_in == '0);
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d = state_q;
        level_d = level_q;
        done_d  = 1'b0;

        if (trig) begin
            // Legato: the attack always continues from whatever level the voice holds now.
            state_d = S_ATTACK;
        end else if (fall && state_q != S_IDLE && state_q != S_RELEASE) begin
            state_d = S_RELEASE;
        end else begin
            case (state_q)
                S_ATTACK: begin
                    if (attack_step_in == '0 || attack_sum >= {1'b0, A_MAX}) begin
                        level_d = A_MAX;
                        state_d = S_DECAY;
                    end else begin
                        level_d = attack_sum[ACC_W-1:0];
                    end
                end
                S_DECAY: begin
                    if (decay_step_in == '0 || {1'b0, level_q} <= decay_floor) begin
                        level_d = sustain_in;
                        state_d = S_SUSTAIN;
                    end else begin
                        level_d = level_q - decay_step_in;
                    end
                end
                S_SUSTAIN: begin
                    level_d = sustain_in;
                end
                S_RELEASE: begin
                    if (rel_instant || level_q <= rel_dec) begin
                        level_d = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        level_d = level_q - rel_dec;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            level_q <= '0;
            gate_q  <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            gate_q  <= gate_in;
            idle_q  <= (state_d == S_IDLE);
            done_q  <= done_d;
        end
    end

    assign level_out     = level_q[ACC_W-1 -: OUT_W];
    assign idle_out      = idle_q;
    assign idle_next_out = (state_d == S_IDLE);
    assign done_out      = done_q;

endmodule

module adsr_poly #(
    parameter int unsigned      NUM_VOICES = 4,
    parameter int unsigned      ACC_W      = 32,
    parameter int unsigned      OUT_W      = 16,
    parameter logic [ACC_W-1:0] A_MAX      = 32'h8000_0000,
    parameter int unsigned      EXP_SHIFT  = 6
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [NUM_VOICES-1:0]       gate_in,
    input  logic [NUM_VOICES-1:0]       retrig_in,
    input  logic [ACC_W-1:0]            attack_step_in,
    input  logic [ACC_W-1:0]            decay_step_in,
    input  logic [ACC_W-1:0]            sustain_level_in,
    input  logic [ACC_W-1:0]            release_step_in,
    output logic [NUM_VOICES*OUT_W-1:0] envelope_out,
    output logic [NUM_VOICES-1:0]       voice_idle_out,
    output logic [NUM_VOICES-1:0]       release_done_out,
    output logic                        all_idle_out
);

    logic [ACC_W-1:0]      sustain_clamped;
    logic [NUM_VOICES-1:0] idle_next;
    logic                  all_idle_q;

    // One clamp shared by every voice; sustain can never sit above the peak.
    assign sustain_clamped = (sustain_level_in > A_MAX) ? A_MAX : sustain_level_in;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        adsr_voice #(
            .ACC_W     (ACC_W),
            .OUT_W     (OUT_W),
            .A_MAX     (A_MAX),
            .EXP_SHIFT (EXP_SHIFT)
        ) u_voice (
            .clk_in          (clk_in),
            .rst_n_in        (rst_n_in),
            .gate_in         (gate_in[v]),
            .retrig_in       (retrig_in[v]),
            .attack_step_in  (attack_step_in),
            .decay_step_in   (decay_step_in),
            .sustain_in      (sustain_clamped),
            .release_step_in (release_step_in),
            .level_out       (envelope_out[v*OUT_W +: OUT_W]),
            .idle_out        (voice_idle_out[v]),
            .idle_next_out   (idle_next[v]),
            .done_out        (release_done_out[v])
        );
    end

    // Registered from the voices' next-state so it lines up with voice_idle_out.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            all_idle_q <= 1'b1;
        end else begin
            all_idle_q <= &idle_next;
        end
    end

    assign all_idle_out = all_idle_q;

endmodule

// File: tb/tb_adsr_poly.sv
// tb_adsr_poly: directed + randomized bench for adsr_poly; a phase/level reference model feeds an
// expected-output queue that a free-running monitor pops and compares after every clock edge.

module tb_adsr_poly;

    localparam int NV = 4;
    localparam longint AMAX = 64'h8000_0000;

    logic           clk_in = 1'b0;
    logic           rst_n_in;
    logic [NV-1:0]  gate;
    logic [NV-1:0]  retrig;
    logic [31:0]    atk_step;
    logic [31:0]    dec_step;
    logic [31:0]    sus_level;
    logic [31:0]    rel_step;
    logic [NV*16-1:0] envelope_out;
    logic [NV-1:0]  voice_idle_out;
    logic [NV-1:0]  release_done_out;
    logic           all_idle_out;

    int n_checks = 0;
    int n_fail   = 0;

    adsr_poly dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .gate_in          (gate),
        .retrig_in        (retrig),
        .attack_step_in   (atk_step),
        .decay_step_in    (dec_step),
        .sustain_level_in (sus_level),
        .release_step_in  (rel_step),
        .envelope_out     (envelope_out),
        .voice_idle_out   (voice_idle_out),
        .release_done_out (release_done_out),
        .all_idle_out     (all_idle_out)
    );

    always #5 clk_in = ~clk_in;

    typedef enum int {P_IDLE, P_ATK, P_DEC, P_SUS, P_REL} phase_t;

    typedef struct {
        logic [NV*16-1:0] env;
        logic [NV-1:0]    idle;
        logic [NV-1:0]    done;
        logic             all_idle;
    } exp_t;

    exp_t   exp_q[$];
    phase_t m_ph[NV];
    longint m_lvl[NV];
    bit     m_gq[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_ph[v]  = P_IDLE;
            m_lvl[v] = 0;
            m_gq[v]  = 1'b0;
        end
    endtask

    // Advances the reference by one clock using the inputs currently driven, queues the result.
    task automatic model_step();
        exp_t   e;
        longint a, d, r, s, rd;
        bit     instant;
        a = longint'({32'd0, atk_step});
        d = longint'({32'd0, dec_step});
        r = longint'({32'd0, rel_step});
        s = longint'({32'd0, sus_level});
        if (s > AMAX) s = AMAX;
        e.done = '0;
        e.idle = '0;
        e.env  = '0;
        for (int v = 0; v < NV; v++) begin
`ifdef ADSR_EXP_RELEASE_EN
            rd = m_lvl[v] >> 6;
            if (rd < ((r == 0) ? 1 : r)) rd = (r == 0) ? 1 : r;
            instant = 1'b0;
`else
            rd = r;
            instant = (r == 0);
`endif
            if (gate[v] && (!m_gq[v] || retrig[v])) begin
                m_ph[v] = P_ATK;
            end else if (!gate[v] && m_gq[v] && (m_ph[v] inside {P_ATK, P_DEC, P_SUS})) begin
                m_ph[v] = P_REL;
            end else begin
                case (m_ph[v])
                    P_ATK: begin
                        if (a == 0 || m_lvl[v] + a >= AMAX) begin
                            m_lvl[v] = AMAX;
                            m_ph[v]  = P_DEC;
                        end else m_lvl[v] = m_lvl[v] + a;
                    end
                    P_DEC: begin
                        if (d == 0 || m_lvl[v] <= s + d) begin
                            m_lvl[v] = s;
                            m_ph[v]  = P_SUS;
                        end else m_lvl[v] = m_lvl[v] - d;
                    end
                    P_SUS: m_lvl[v] = s;
                    P_REL: begin
                        if (instant || m_lvl[v] <= rd) begin
                            m_lvl[v]  = 0;
                            m_ph[v]   = P_IDLE;
                            e.done[v] = 1'b1;
                        end else m_lvl[v] = m_lvl[v] - rd;
                    end
                    default: ;
                endcase
            end
            m_gq[v] = gate[v];
            e.env[v*16 +: 16] = 16'(m_lvl[v] >> 16);
            e.idle[v] = (m_ph[v] == P_IDLE);
        end
        e.all_idle = &e.idle;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk_in);
            #2;
            retrig = '0;
        end
    endtask

    task automatic set_cfg(input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] s, input logic [31:0] r);
        atk_step  = a;
        dec_step  = d;
        sus_level = s;
        rel_step  = r;
    endtask

    // Asserts reset away from the clock edge, checks the async clear, and releases with gates low.
    task automatic do_reset(input string tag);
        rst_n_in = 1'b0;
        #1;
        check({tag, "_env"}, envelope_out, '0);
        check({tag, "_idle"}, voice_idle_out, {NV{1'b1}});
        check({tag, "_done"}, release_done_out, '0);
        check({tag, "_all_idle"}, all_idle_out, 1'b1);
        model_reset();
        gate   = '0;
        retrig = '0;
        @(posedge clk_in);
        #1;
        check({tag, "_done_held"}, release_done_out, '0);
        #1;
        rst_n_in = 1'b1;
    endtask

    task automatic random_cfg();
        logic [31:0] a, d, s, r;
        a = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom & 32'h1FFF_FFFF) | 32'h0100_0000);
        d = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom & 32'h0FFF_FFFF) | 32'h0080_0000);
        r = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom & 32'h0FFF_FFFF) | 32'h0080_0000);
        case ($urandom_range(0, 3))
            0:       s = 32'hFFFF_FFFF;
            1:       s = 32'd0;
            default: s = $urandom;
        endcase
        set_cfg(a, d, s, r);
    endtask

    // Monitor: outputs are presented every cycle, so one queued expectation is consumed per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_envelope", envelope_out, e.env);
                check("sb_voice_idle", voice_idle_out, e.idle);
                check("sb_release_done", release_done_out, e.done);
                check("sb_all_idle", all_idle_out, e.all_idle);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_in = 1'b0;
        gate     = '0;
        retrig   = '0;
        set_cfg(32'h1000_0000, 32'h0800_0000, 32'h4000_0000, 32'h0400_0000);
        model_reset();
        repeat (2) @(posedge clk_in);
        #2;
        check("reset_env", envelope_out, '0);
        check("reset_idle", voice_idle_out, 4'hF);
        check("reset_done", release_done_out, '0);
        check("reset_all_idle", all_idle_out, 1'b1);
        rst_n_in = 1'b1;
        tick(2);

        // Basic envelope on voice 0
        gate[0] = 1'b1;
        tick(1);
        tick(7);
        check("basic_attack_7", envelope_out[15:0], 16'h7000);
        tick(1);
        check("basic_attack_peak", envelope_out[15:0], 16'h8000);
        tick(8);
        check("basic_decay_sustain", envelope_out[15:0], 16'h4000);
        tick(23);
        check("basic_sustain_hold", envelope_out[15:0], 16'h4000);
        gate[0] = 1'b0;
        tick(1);
        tick(15);
        check("basic_release_15", envelope_out[15:0], 16'h0400);
        check("basic_no_early_done", release_done_out[0], 1'b0);
        tick(1);
        check("basic_release_zero", envelope_out[15:0], 16'h0000);
        check("basic_done_pulse", release_done_out[0], 1'b1);
        check("basic_idle", voice_idle_out[0], 1'b1);
        tick(1);
        check("basic_done_once", release_done_out[0], 1'b0);

        // Early release after three attack edges
        gate[0] = 1'b1;
        tick(1);
        tick(3);
        check("early_attack_3", envelope_out[15:0], 16'h3000);
        gate[0] = 1'b0;
        tick(1);
        check("early_release_entry", envelope_out[15:0], 16'h3000);
        tick(11);
        check("early_release_11", envelope_out[15:0], 16'h0400);
        tick(1);
        check("early_release_zero", envelope_out[15:0], 16'h0000);
        check("early_done_pulse", release_done_out[0], 1'b1);

        // Legato retrigger on voice 1 from sustain
        gate[1] = 1'b1;
        tick(1);
        tick(16);
        tick(2);
        check("legato_sustain", envelope_out[31:16], 16'h4000);
        retrig[1] = 1'b1;
        tick(1);
        tick(3);
        check("legato_attack_3", envelope_out[31:16], 16'h7000);
        tick(1);
        check("legato_peak", envelope_out[31:16], 16'h8000);
        gate[1] = 1'b0;
        tick(40);

        // Instantaneous phases with sustain clamp on voice 2
        set_cfg(32'd0, 32'd0, 32'hFFFF_FFFF, 32'h0400_0000);
        gate[2] = 1'b1;
        tick(1);
        tick(1);
        check("instant_peak", envelope_out[47:32], 16'h8000);
        tick(3);
        check("instant_clamp_sustain", envelope_out[47:32], 16'h8000);
        gate[2] = 1'b0;
        tick(40);
        check("instant_all_idle", all_idle_out, 1'b1);

        // Staggered voices, then reset mid-decay
        set_cfg(32'h1000_0000, 32'h0800_0000, 32'h4000_0000, 32'h0400_0000);
        for (int v = 0; v < NV; v++) begin
            gate[v] = 1'b1;
            tick(1);
        end
        tick(10);
        check("stagger_levels", envelope_out, 64'h7000_6800_6000_5800);
        do_reset("mid_reset");
        tick(3);

        // Randomized traffic, including one reset in the middle
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) random_cfg();
            for (int v = 0; v < NV; v++) begin
                if ($urandom_range(0, 23) == 0) gate[v] = ~gate[v];
                if ($urandom_range(0, 49) == 0) retrig[v] = 1'b1;
            end
            if (c == 1700) do_reset("rand_reset");
            tick(1);
        end

        gate = '0;
        set_cfg(32'h1000_0000, 32'h0800_0000, 32'h4000_0000, 32'd0);
        tick(3);
        check("final_all_idle", all_idle_out, 1'b1);
        #10;
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
